// File: rtl/rect_compositor.sv
// Rectangle overlay compositor: double-buffered slot records (shadow/active) and a
// two-stage pixel pipeline that paints the lowest-index hitting rectangle over bg.
module rect_compositor #(
    parameter int NUM_RECTS  = 4,
    parameter int CORD_W     = 16,
    parameter int COLOR_BITS = 4,
    parameter int H_OFFSET   = 0,
    parameter int V_OFFSET   = 0,
    localparam int REC_W     = 4*CORD_W + 3*COLOR_BITS + 1,
    localparam int IDX_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix_n,
    input  logic                  de,
    input  logic [CORD_W-1:0]     sx,
    input  logic [CORD_W-1:0]     sy,
    input  logic                  frame_start,
    input  logic                  is_sym_mode,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [REC_W-1:0]      wr_data,
    input  logic                  wr_commit,
    output logic                  commit_pending,
    input  logic [COLOR_BITS-1:0] bg_r,
    input  logic [COLOR_BITS-1:0] bg_g,
    input  logic [COLOR_BITS-1:0] bg_b,
    output logic                  de_o,
    output logic [COLOR_BITS-1:0] dispcolor_r,
    output logic [COLOR_BITS-1:0] dispcolor_g,
    output logic [COLOR_BITS-1:0] dispcolor_b
);

    localparam int SUM_W = CORD_W + 2;
    localparam int COL_W = 3*COLOR_BITS;
    localparam logic [SUM_W-1:0] H_OFF = SUM_W'(H_OFFSET);
    localparam logic [SUM_W-1:0] V_OFF = SUM_W'(V_OFFSET);

    logic [REC_W-1:0]     shadow_q [NUM_RECTS];
    logic [REC_W-1:0]     active_q [NUM_RECTS];
    logic                 pending_q, pending_d;
    logic                 wr_fire;
    logic                 copy_now;
    logic [NUM_RECTS-1:0] hit_d, hit_q;
    logic                 mode_q, de1_q;
    logic [COL_W-1:0]     col_sel, col_d, col_q;
    logic                 de2_q;

    assign wr_ready       = !pending_q;
    assign commit_pending = pending_q;
    assign wr_fire        = wr_valid && !pending_q && (32'(wr_idx) < NUM_RECTS);
    assign copy_now       = frame_start && pending_q;

    // A commit raised on a frame_start cycle only arms; the copy waits for the next frame.
    always_comb begin
        pending_d = pending_q;
        if (copy_now)
            pending_d = 1'b0;
        else if (wr_commit)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            pending_q <= 1'b0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            if (wr_fire)
                shadow_q[wr_idx] <= wr_data;
            if (copy_now)
                active_q <= shadow_q;
        end
    end

    logic [SUM_W-1:0] sx_ext, sy_ext;
    assign sx_ext = {2'b00, sx};
    assign sy_ext = {2'b00, sy};

    // Extended-width sums let rectangles run off the right/bottom edge without wrapping.
    for (genvar i = 0; i < NUM_RECTS; i++) begin : g_slot
        logic [CORD_W-1:0] rh, rw, rx, ry;
        logic              en;
        logic [SUM_W-1:0]  x_lo, x_hi, y_lo, y_hi;

        assign rh   = active_q[i][CORD_W-1:0];
        assign rw   = active_q[i][2*CORD_W-1:CORD_W];
        assign rx   = active_q[i][3*CORD_W-1:2*CORD_W];
        assign ry   = active_q[i][4*CORD_W-1:3*CORD_W];
        assign en   = active_q[i][REC_W-1];
        assign x_lo = {2'b00, rx} + H_OFF;
        assign x_hi = x_lo + {2'b00, rw};
        assign y_lo = {2'b00, ry} + V_OFF;
        assign y_hi = y_lo + {2'b00, rh};

        assign hit_d[i] = en && (rw != '0) && (rh != '0)
                        && (sx_ext >= x_lo) && (sx_ext < x_hi)
                        && (sy_ext >= y_lo) && (sy_ext < y_hi);
    end

    always_comb begin
        col_sel = {bg_b, bg_g, bg_r};
        for (int i = NUM_RECTS-1; i >= 0; i--) begin
            if (hit_q[i])
                col_sel = active_q[i][4*CORD_W +: COL_W];
        end
        col_d = (de1_q && mode_q) ? col_sel : '0;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            hit_q  <= '0;
            mode_q <= 1'b0;
            de1_q  <= 1'b0;
            col_q  <= '0;
            de2_q  <= 1'b0;
        end else begin
            hit_q  <= hit_d;
            mode_q <= is_sym_mode;
            de1_q  <= de;
            col_q  <= col_d;
            de2_q  <= de1_q;
        end
    end

    assign de_o        = de2_q;
    assign dispcolor_r = col_q[COLOR_BITS-1:0];
    assign dispcolor_g = col_q[2*COLOR_BITS-1:COLOR_BITS];
    assign dispcolor_b = col_q[3*COLOR_BITS-1:2*COLOR_BITS];

endmodule

// File: tb/tb_rect_compositor.sv
// Directed bench for rect_compositor: handshake, commit timing, priority, clipping,
// masking, pipeline alignment and reset, with hand-computed expected colours.
module tb_rect_compositor;

    localparam int NR    = 3;
    localparam int CW    = 16;
    localparam int CB    = 4;
    localparam int HO    = 3;
    localparam int VO    = 2;
    localparam int RW    = 4*CW + 3*CB + 1;
    localparam logic [11:0] BG = 12'h567;

    logic          clk_pix = 1'b0;
    logic          rst_pix_n = 1'b0;
    logic          de = 1'b0;
    logic [CW-1:0] sx = '0, sy = '0;
    logic          frame_start = 1'b0;
    logic          is_sym_mode = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [1:0]    wr_idx = '0;
    logic [RW-1:0] wr_data = '0;
    logic          wr_commit = 1'b0;
    logic          commit_pending;
    logic [CB-1:0] bg_r = 4'h5, bg_g = 4'h6, bg_b = 4'h7;
    logic          de_o;
    logic [CB-1:0] dispcolor_r, dispcolor_g, dispcolor_b;

    int n_checks = 0;
    int n_errors = 0;

    rect_compositor #(
        .NUM_RECTS(NR), .CORD_W(CW), .COLOR_BITS(CB), .H_OFFSET(HO), .V_OFFSET(VO)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .de(de), .sx(sx), .sy(sy),
        .frame_start(frame_start), .is_sym_mode(is_sym_mode),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_commit(wr_commit), .commit_pending(commit_pending),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .de_o(de_o),
        .dispcolor_r(dispcolor_r), .dispcolor_g(dispcolor_g), .dispcolor_b(dispcolor_b)
    );

    always #5 clk_pix = ~clk_pix;

    function automatic logic [RW-1:0] mk(input logic [CW-1:0] x, y, w, h,
                                         input logic [CB-1:0] r, g, b, input logic en);
        return {en, b, g, r, y, x, w, h};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb();
        return {dispcolor_r, dispcolor_g, dispcolor_b};
    endfunction

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [RW-1:0] rec);
        int n = 0;
        while (!wr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!wr_ready) check_eq("wr_ready_timeout", 32'(wr_ready), 32'd1);
        wr_idx   = idx;
        wr_data  = rec;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [CW-1:0] x, y, input logic [11:0] exp);
        sx = x;
        sy = y;
        de = 1'b1;
        is_sym_mode = 1'b1;
        tick();
        tick();
        check_eq(tag, 32'(rgb()), 32'(exp));
        de = 1'b0;
    endtask

    // de / mode sequences, bit i is cycle i
    localparam logic [5:0] S_DE    = 6'b101101;
    localparam logic [5:0] S_MODE  = 6'b101011;
    localparam logic [5:0] EXP_DE  = 6'b101101;
    localparam logic [5:0] EXP_HIT = 6'b101001;

    initial begin
        #3;
        check_eq("rst_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_color", 32'(rgb()), 32'd0);
        check_eq("rst_de_o", 32'(de_o), 32'd0);
        check_eq("rst_pending", 32'(commit_pending), 32'd0);
        tick();
        tick();
        rst_pix_n = 1'b1;
        tick();
        check_eq("post_rst_ready", 32'(wr_ready), 32'd1);

        // single rectangle, only visible after commit + frame_start
        write_slot(2'd0, mk(16'd10, 16'd10, 16'd4, 16'd2, 4'hF, 4'h0, 4'h0, 1'b1));
        pix("shadow_not_drawn", 16'd16, 16'd13, BG);
        commit();
        check_eq("pending_set", 32'(commit_pending), 32'd1);
        check_eq("ready_low", 32'(wr_ready), 32'd0);
        frame();
        check_eq("pending_clr", 32'(commit_pending), 32'd0);
        pix("hit_inner", 16'd16, 16'd13, 12'hF00);
        pix("hit_left_edge", 16'd13, 16'd12, 12'hF00);
        pix("miss_right", 16'd17, 16'd13, BG);
        pix("miss_bottom", 16'd16, 16'd14, BG);

        // priority, then disable slot0 with commit on a frame_start cycle
        write_slot(2'd0, mk(16'd10, 16'd10, 16'd4, 16'd2, 4'h0, 4'hF, 4'h0, 1'b1));
        write_slot(2'd1, mk(16'd13, 16'd11, 16'd4, 16'd4, 4'h0, 4'h0, 4'hF, 1'b1));
        commit();
        frame();
        pix("prio_low_idx", 16'd16, 16'd13, 12'h0F0);
        write_slot(2'd0, mk(16'd10, 16'd10, 16'd4, 16'd2, 4'h0, 4'hF, 4'h0, 1'b0));
        wr_commit = 1'b1;
        frame_start = 1'b1;
        tick();
        wr_commit = 1'b0;
        frame_start = 1'b0;
        check_eq("same_cycle_pending", 32'(commit_pending), 32'd1);
        pix("same_cycle_no_copy", 16'd16, 16'd13, 12'h0F0);
        frame();
        pix("prio_after_disable", 16'd16, 16'd13, 12'h00F);

        // masking and 2-cycle alignment over a hitting pixel
        sx = 16'd16;
        sy = 16'd13;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                de = S_DE[i];
                is_sym_mode = S_MODE[i];
            end else begin
                de = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 6) begin
                check_eq($sformatf("stream_col%0d", i-1), 32'(rgb()),
                         EXP_HIT[i-1] ? 32'h00F : 32'h000);
                check_eq($sformatf("stream_de%0d", i-1), 32'(de_o), 32'(EXP_DE[i-1]));
            end
        end

        // writes stall while pending, accepted on the cycle after the copy
        commit();
        wr_idx   = 2'd2;
        wr_data  = mk(16'd30, 16'd30, 16'd2, 16'd2, 4'hF, 4'hF, 4'h0, 1'b1);
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("stall_ready%0d", i), 32'(wr_ready), 32'd0);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("ready_after_copy", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        pix("stalled_write_not_copied", 16'd33, 16'd32, BG);
        commit();
        frame();
        pix("late_write_drawn", 16'd33, 16'd32, 12'hFF0);

        // zero width never hits; out-of-range slot index is discarded
        write_slot(2'd2, mk(16'd30, 16'd30, 16'd0, 16'd2, 4'hF, 4'hF, 4'h0, 1'b1));
        write_slot(2'd3, mk(16'd40, 16'd40, 16'd2, 16'd2, 4'hF, 4'hF, 4'hF, 1'b1));
        commit();
        frame();
        pix("zero_width", 16'd33, 16'd32, BG);
        pix("idx_out_of_range", 16'd43, 16'd42, BG);

        // right-edge clipping without wrap
        write_slot(2'd2, mk(16'hFFF0, 16'd50, 16'h0020, 16'd1, 4'h1, 4'h2, 4'h3, 1'b1));
        commit();
        frame();
        pix("clip_no_wrap", 16'h0005, 16'd52, BG);
        pix("clip_drawn", 16'hFFF8, 16'd52, 12'h123);
        pix("clip_lo_edge", 16'hFFF3, 16'd52, 12'h123);
        pix("clip_below_lo", 16'hFFF2, 16'd52, BG);

        // reset mid-operation with a commit pending
        commit();
        sx = 16'd16;
        sy = 16'd13;
        de = 1'b1;
        is_sym_mode = 1'b1;
        tick();
        tick();
        check_eq("pre_rst_color", 32'(rgb()), 32'h00F);
        #2 rst_pix_n = 1'b0;
        #1;
        check_eq("async_rst_color", 32'(rgb()), 32'd0);
        check_eq("async_rst_de_o", 32'(de_o), 32'd0);
        check_eq("async_rst_pending", 32'(commit_pending), 32'd0);
        check_eq("async_rst_ready", 32'(wr_ready), 32'd1);
        @(posedge clk_pix);
        #1 rst_pix_n = 1'b1;
        de = 1'b0;
        frame();
        check_eq("post_rst_pending", 32'(commit_pending), 32'd0);
        pix("post_rst_no_rects", 16'd16, 16'd13, BG);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
